// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated, byte-addressed, little-endian data RAM that
// serves the EX/MEM load/store request and returns the extended load result
// for MEM/WB. The pipeline is held with `stall` until each access completes.
module dmem_responder #(
   parameter int DEPTH   = 512,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_func3,
   output logic        stall,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        err,
   output logic [1:0]  dbg_state
);

   // Handshake: a request (req_read|req_write) is accepted in IDLE. While
   // `stall` is high the requester keeps every req_* stable; the access
   // completes in the DONE cycle (stall low, rd_valid/err/rd_data valid) and
   // the requester advances to its next instruction at the end of that cycle.

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] cnt;

   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic [2:0]    lat_func3;
   logic          lat_read;
   logic          lat_write;

   logic [31:0]   mem [DEPTH];

   // Request as seen by the access logic: live inputs in IDLE (needed when
   // LATENCY=1 goes straight to DONE), latched copy otherwise.
   logic          in_idle;
   logic [31:0]   eff_addr;
   logic [31:0]   eff_wdata;
   logic [2:0]    eff_func3;
   logic          is_store;
   logic          is_load;
   logic [AW-1:0] eff_idx;
   logic [1:0]    lane;
   logic          bad;
   logic          enter_done;
   logic [31:0]   ram_word;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_val;
   logic [3:0]    wmask;
   logic [31:0]   wdata_al;

   assign in_idle   = (state == S_IDLE);
   assign eff_addr  = in_idle ? req_addr  : lat_addr;
   assign eff_wdata = in_idle ? req_wdata : lat_wdata;
   assign eff_func3 = in_idle ? req_func3 : lat_func3;
   assign is_store  = in_idle ? req_write : lat_write;
   assign is_load   = (in_idle ? req_read : lat_read) & ~is_store;
   assign eff_idx   = eff_addr[AW+1:2];
   assign lane      = eff_addr[1:0];
   assign dbg_state = state;

   // Next-state and stall; reset forces stall low in the same cycle.
   always_comb begin
      next_state = state;
      stall      = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_read || req_write) begin
               stall      = 1'b1;
               next_state = (LATENCY > 1) ? S_BUSY : S_DONE;
            end
         end
         S_BUSY: begin
            stall = 1'b1;
            if (cnt == CW'(1)) next_state = S_DONE;
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
      if (reset) stall = 1'b0;
   end

   assign enter_done = (next_state == S_DONE) && (state != S_DONE) && !reset;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Latch the request on acceptance and count down the wait states.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_func3 <= '0;
         lat_read  <= 1'b0;
         lat_write <= 1'b0;
      end else if (in_idle && (req_read || req_write)) begin
         cnt       <= CNT_INIT;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
         lat_func3 <= req_func3;
         lat_read  <= req_read;
         lat_write <= req_write;
      end else if (state == S_BUSY) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Decode legality, load extension and store lane placement.
   always_comb begin
      bad      = 1'b0;
      load_val = '0;
      wmask    = 4'b0000;
      wdata_al = eff_wdata;
      ram_word = mem[eff_idx];
      byte_sel = ram_word[8*lane +: 8];
      half_sel = lane[1] ? ram_word[31:16] : ram_word[15:0];
      if (is_store) begin
         if (eff_func3 != 3'b000 && eff_func3 != 3'b001 && eff_func3 != 3'b010) bad = 1'b1;
      end else begin
         if (eff_func3 == 3'b011 || eff_func3 == 3'b110 || eff_func3 == 3'b111) bad = 1'b1;
      end
      if (eff_func3[1:0] == 2'b01 && lane[0]) bad = 1'b1;
      if (eff_func3[1:0] == 2'b10 && lane != 2'b00) bad = 1'b1;
      case (eff_func3)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b010:  load_val = ram_word;
         3'b100:  load_val = {24'd0, byte_sel};
         3'b101:  load_val = {16'd0, half_sel};
         default: load_val = '0;
      endcase
      case (eff_func3)
         3'b000: begin
            wmask    = 4'b0001 << lane;
            wdata_al = {4{eff_wdata[7:0]}};
         end
         3'b001: begin
            wmask    = lane[1] ? 4'b1100 : 4'b0011;
            wdata_al = {2{eff_wdata[15:0]}};
         end
         3'b010:  wmask = 4'b1111;
         default: wmask = 4'b0000;
      endcase
   end

   // RAM write on the edge entering DONE; contents survive reset.
   always_ff @(posedge clk) begin
      if (enter_done && is_store && !bad) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask[b]) mem[eff_idx][8*b +: 8] <= wdata_al[8*b +: 8];
         end
      end
   end

   // Response registers: one-cycle pulses, rd_data holds between accesses.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         err      <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         err      <= 1'b0;
         if (enter_done) begin
            err      <= bad;
            rd_valid <= is_load;
            if (bad)          rd_data <= '0;
            else if (is_load) rd_data <= load_val;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: a LATENCY=2 instance (a) and a LATENCY=1
// instance (b). Expected responses are queued as {err, rd_valid, rd_data}.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   logic        reset_a, req_read_a, req_write_a;
   logic [31:0] req_addr_a, req_wdata_a;
   logic [2:0]  req_func3_a;
   logic        stall_a, rd_valid_a, err_a;
   logic [31:0] rd_data_a;
   logic [1:0]  dbg_state_a;

   logic        reset_b, req_read_b, req_write_b;
   logic [31:0] req_addr_b, req_wdata_b;
   logic [2:0]  req_func3_b;
   logic        stall_b, rd_valid_b, err_b;
   logic [31:0] rd_data_b;
   logic [1:0]  dbg_state_b;

   logic [33:0] exp_a_q[$];
   logic [33:0] exp_b_q[$];

   dmem_responder #(.DEPTH(512), .LATENCY(2)) dut_a (
      .clk(clk), .reset(reset_a), .req_read(req_read_a), .req_write(req_write_a),
      .req_addr(req_addr_a), .req_wdata(req_wdata_a), .req_func3(req_func3_a),
      .stall(stall_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .err(err_a),
      .dbg_state(dbg_state_a)
   );

   dmem_responder #(.DEPTH(512), .LATENCY(1)) dut_b (
      .clk(clk), .reset(reset_b), .req_read(req_read_b), .req_write(req_write_b),
      .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_func3(req_func3_b),
      .stall(stall_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .err(err_b),
      .dbg_state(dbg_state_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic void exp_push(input bit b, input logic e, input logic v, input logic [31:0] d);
      if (b) exp_b_q.push_back({e, v, d});
      else   exp_a_q.push_back({e, v, d});
   endfunction

   task automatic drive(input bit b, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3);
      if (b) begin
         req_read_b = rd; req_write_b = wr; req_addr_b = a; req_wdata_b = wd; req_func3_b = f3;
      end else begin
         req_read_a = rd; req_write_a = wr; req_addr_a = a; req_wdata_a = wd; req_func3_a = f3;
      end
   endtask

   // One full access: present the request, count stall cycles up to DONE,
   // then withdraw it so the next access starts right after DONE.
   task automatic access(input bit b, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3, input int exp_lat,
                         output int done_cyc);
      int n;
      logic s;
      @(posedge clk); #1;
      drive(b, rd, wr, a, wd, f3);
      n = 0;
      done_cyc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         s = b ? stall_b : stall_a;
         if (!s) begin
            done_cyc = cyc;
            break;
         end
         n++;
      end
      drive(b, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      chk(b ? "stall_len_b" : "stall_len_a", n, exp_lat);
   endtask

   // Monitor for instance a: every response pulse pops the scoreboard.
   always @(negedge clk) begin
      logic [33:0] e;
      if (rd_valid_a || err_a) begin
         checks++;
         if (exp_a_q.size() == 0) begin
            failures++;
            $display("FAIL resp_a: unexpected err=%0b valid=%0b data=0x%08h", err_a, rd_valid_a, rd_data_a);
         end else begin
            e = exp_a_q.pop_front();
            if ({err_a, rd_valid_a, rd_data_a} !== e) begin
               failures++;
               $display("FAIL resp_a: got err=%0b valid=%0b data=0x%08h expected err=%0b valid=%0b data=0x%08h",
                        err_a, rd_valid_a, rd_data_a, e[33], e[32], e[31:0]);
            end
         end
      end
   end

   // Monitor for instance b.
   always @(negedge clk) begin
      logic [33:0] e;
      if (rd_valid_b || err_b) begin
         checks++;
         if (exp_b_q.size() == 0) begin
            failures++;
            $display("FAIL resp_b: unexpected err=%0b valid=%0b data=0x%08h", err_b, rd_valid_b, rd_data_b);
         end else begin
            e = exp_b_q.pop_front();
            if ({err_b, rd_valid_b, rd_data_b} !== e) begin
               failures++;
               $display("FAIL resp_b: got err=%0b valid=%0b data=0x%08h expected err=%0b valid=%0b data=0x%08h",
                        err_b, rd_valid_b, rd_data_b, e[33], e[32], e[31:0]);
            end
         end
      end
   end

   initial begin
      int d0, d1, dx;
      reset_a = 1'b1;
      reset_b = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      repeat (3) @(posedge clk);
      #1;
      reset_a = 1'b0;
      reset_b = 1'b0;
      @(negedge clk);
      chk("reset_stall", {31'd0, stall_a}, 32'd0);
      chk("reset_rd_data", rd_data_a, 32'd0);
      chk("reset_pulses", {30'd0, rd_valid_a, err_a}, 32'd0);
      chk("reset_state", {30'd0, dbg_state_a}, 32'd0);

      // Word round trip.
      access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 2, dx);
      exp_push(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
      access(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010, 2, dx);

      // Byte access.
      access(1'b0, 1'b0, 1'b1, 32'h13, 32'h00000080, 3'b000, 2, dx);
      exp_push(1'b0, 1'b0, 1'b1, 32'hFFFFFF80);
      access(1'b0, 1'b1, 1'b0, 32'h13, 32'd0, 3'b000, 2, dx);
      exp_push(1'b0, 1'b0, 1'b1, 32'h00000080);
      access(1'b0, 1'b1, 1'b0, 32'h13, 32'd0, 3'b100, 2, dx);
      exp_push(1'b0, 1'b0, 1'b1, 32'h80ADBEEF);
      access(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010, 2, dx);

      // Half access.
      access(1'b0, 1'b0, 1'b1, 32'h12, 32'h00008001, 3'b001, 2, dx);
      exp_push(1'b0, 1'b0, 1'b1, 32'hFFFF8001);
      access(1'b0, 1'b1, 1'b0, 32'h12, 32'd0, 3'b001, 2, dx);
      exp_push(1'b0, 1'b0, 1'b1, 32'h00008001);
      access(1'b0, 1'b1, 1'b0, 32'h12, 32'd0, 3'b101, 2, dx);
      exp_push(1'b0, 1'b0, 1'b1, 32'h8001BEEF);
      access(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010, 2, dx);

      // Errors: misaligned load, misaligned half store, illegal store func3.
      exp_push(1'b0, 1'b1, 1'b1, 32'd0);
      access(1'b0, 1'b1, 1'b0, 32'h11, 32'd0, 3'b010, 2, dx);
      exp_push(1'b0, 1'b1, 1'b0, 32'd0);
      access(1'b0, 1'b0, 1'b1, 32'h11, 32'h0000FFFF, 3'b001, 2, dx);
      exp_push(1'b0, 1'b1, 1'b0, 32'd0);
      access(1'b0, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 3'b011, 2, dx);
      exp_push(1'b0, 1'b0, 1'b1, 32'h8001BEEF);
      access(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010, 2, dx);

      // Read and write together is a store: no rd_valid pulse.
      access(1'b0, 1'b1, 1'b1, 32'h24, 32'hA5A5A5A5, 3'b010, 2, dx);
      exp_push(1'b0, 1'b0, 1'b1, 32'hA5A5A5A5);
      access(1'b0, 1'b1, 1'b0, 32'h24, 32'd0, 3'b010, 2, dx);

      // Reset mid-access discards the in-flight store.
      access(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 3'b010, 2, dx);
      exp_push(1'b0, 1'b0, 1'b1, 32'h12345678);
      access(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 3'b010, 2, dx);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 3'b010);
      @(negedge clk);
      chk("rst_idle_stall", {31'd0, stall_a}, 32'd1);
      @(posedge clk); #1;
      reset_a = 1'b1;
      @(negedge clk);
      chk("rst_busy_stall", {31'd0, stall_a}, 32'd0);
      @(posedge clk); #1;
      reset_a = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      @(negedge clk);
      chk("rst_after_stall", {31'd0, stall_a}, 32'd0);
      chk("rst_after_rd_data", rd_data_a, 32'd0);
      chk("rst_after_pulses", {30'd0, rd_valid_a, err_a}, 32'd0);
      chk("rst_after_state", {30'd0, dbg_state_a}, 32'd0);
      exp_push(1'b0, 1'b0, 1'b1, 32'h12345678);
      access(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 3'b010, 2, dx);

      // LATENCY=1 instance: back-to-back loads and address wrap.
      access(1'b1, 1'b0, 1'b1, 32'h0, 32'h11111111, 3'b010, 1, dx);
      access(1'b1, 1'b0, 1'b1, 32'h4, 32'h22222222, 3'b010, 1, dx);
      exp_push(1'b1, 1'b0, 1'b1, 32'h11111111);
      access(1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 3'b010, 1, d0);
      exp_push(1'b1, 1'b0, 1'b1, 32'h22222222);
      access(1'b1, 1'b1, 1'b0, 32'h4, 32'd0, 3'b010, 1, d1);
      chk("b2b_done_gap", d1 - d0, 32'd2);
      access(1'b1, 1'b0, 1'b1, 32'h800, 32'h33333333, 3'b010, 1, dx);
      exp_push(1'b1, 1'b0, 1'b1, 32'h33333333);
      access(1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 3'b010, 1, dx);
      exp_push(1'b1, 1'b0, 1'b1, 32'h22222222);
      access(1'b1, 1'b1, 1'b0, 32'h804, 32'd0, 3'b010, 1, dx);

      repeat (4) @(negedge clk);
      chk("drain_a", exp_a_q.size(), 32'd0);
      chk("drain_b", exp_b_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the five-stage pipeline: serves the load/store request carried by the EX/MEM pipeline register and returns the load result destined for the MEM/WB register's MemReadData field. Models a wait-stated, byte-addressed, little-endian data RAM. Holds the pipeline with a stall signal until each access completes. Handles RV32I byte, half and word widths, including sign and zero extension.

## Interface
- `DEPTH`, 512: RAM size in 32-bit words; power of two.
- `LATENCY`, 2: cycles `stall` is high per access; legal values ≥1.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_read` in 1: load request (EX/MEM MemRead).
- `req_write` in 1: store request (EX/MEM MemWrite).
- `req_addr` in 32: byte address (EX/MEM Alu_Result).
- `req_wdata` in 32: store data (EX/MEM RD_Two).
- `req_func3` in 3: access width/sign (EX/MEM func3).
- `stall` out 1: pipeline hold; EX/MEM and earlier registers must not advance while high.
- `rd_data` out 32: extended load result, to MEM/WB MemReadData.
- `rd_valid` out 1: one-cycle pulse, load completed.
- `err` out 1: one-cycle pulse, misaligned address or illegal func3.

## Operation
- Word index is `req_addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4·DEPTH.
- Load func3 values:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Store func3 values:
  - 000 SB: write byte lane `addr[1:0]`.
  - 001 SH: write half at `addr[1]`.
  - 010 SW: write full word.
- Misaligned accesses: LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0.
- Illegal func3: any value not listed for the access type.
- On a misaligned or illegal access: no RAM write, `rd_data`=0, `err` pulses. `rd_valid` still pulses if the access is a read.
- If `req_read` and `req_write` are both high, the access is a store and `rd_valid` does not pulse.
- FSM:
  - **IDLE**: on a request, latch addr, wdata, func3 and type; load the counter with LATENCY−1. Go to BUSY if LATENCY>1, otherwise DONE.
  - **BUSY**: decrement the counter; go to DONE when the counter equals 1.
  - **DONE**: go to IDLE unconditionally. The request still present in this cycle is the same instruction and is not restarted.
- The RAM write and the `rd_data`/`rd_valid`/`err` registers update on the clock edge entering DONE. A load reads the RAM contents before that edge.
- `stall` is combinational: `(IDLE && (req_read|req_write)) || BUSY`, forced 0 while `reset` is high.
- `rd_data` holds its last value until the next DONE entry.
- Reset:
  - FSM goes to IDLE; `rd_data`=0, `rd_valid`=0, `err`=0, `stall`=0.
  - An in-flight store is discarded.
  - RAM contents are unaffected.

## Timing
- A request first presented in cycle 0 holds `stall` high in cycles 0..LATENCY−1.
- In cycle LATENCY (DONE): `stall`=0, with `rd_valid`/`err`/`rd_data` valid. The pipeline advances at the end of that cycle.
- Throughput: one access per LATENCY+1 cycles. The next instruction's request is sampled in IDLE at cycle LATENCY+1.
- The requester holds all `req_*` stable while `stall` is high. Changes during BUSY are ignored because the request is latched.
- A store followed immediately by a load to the same address returns the new data.
- Reset asserted in any state takes effect on the next edge. `stall` drops the same cycle `reset` is high.

## Test plan
- **Word round trip** (LATENCY=2): SW 0xDEADBEEF to 0x10, then LW 0x10.
  - Each access: `stall` high 2 cycles.
  - The LW's DONE cycle shows `rd_valid`=1 and `rd_data`=0xDEADBEEF.
- **Byte access**: after the word round trip, SB 0x80 to 0x13.
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LW 0x10 → 0x80ADBEEF.
- **Half access**: SH 0x8001 to 0x12.
  - LH 0x12 → 0xFFFF8001.
  - LHU 0x12 → 0x00008001.
  - LW 0x10 → 0x8001BEEF.
- **Errors**:
  - LW 0x11 → `err`=1, `rd_valid`=1, `rd_data`=0.
  - SH 0x11 and a store with func3=011 → `err`=1.
  - LW 0x10 afterwards is unchanged.
- **Reset mid-access**: LW 0x20 returns 0x12345678, then start SW 0xCAFEF00D to 0x20 and assert `reset` during BUSY.
  - `stall`=0 and outputs are 0 after the edge.
  - A subsequent LW 0x20 returns 0x12345678.
- **LATENCY=1 instance with address wrap**:
  - Back-to-back LW 0x0 and LW 0x4: `stall` high exactly 1 cycle each, with DONE cycles 2 apart.
  - With DEPTH=512, an address of 0x800 aliases 0x0.
